bp_cce_cfg_loader: RTL and testbench

Boot-time configuration sequencer for a single bp_cce_fsm_top instance. After reset it holds the CCE frozen, streams (address, data) configuration words from a synchronous ROM onto the CCE config write channel, then releases freeze. It sits between a per-tile config ROM and the CCE's cfg_w_v_i/cfg_addr_i/cfg_data_i/freeze_i inputs, replacing testbench-driven configuration.

---
 rtl/bp_cce_cfg_loader.sv | 137 +++++++++++++
 tb/tb_bp_cce_cfg_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_cfg_loader.sv
// bp_cce_cfg_loader
//
// Boot-time configuration sequencer for one CCE. Out of reset it holds the
// CCE frozen, walks a synchronous config ROM entry by entry, presents each
// (address, data) pair on the config write channel with a valid/ready
// handshake, and releases freeze once the ROM is exhausted or a terminator
// entry (address field all ones) is read. A restart request in DONE replays
// the whole sequence.
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   reset_n_i    synchronous active-low reset
//   restart_i    reload request, honoured only in DONE
//   rom_addr_o   ROM read index (always equals the internal index)
//   rom_data_i   ROM entry {addr, data}, valid the cycle after rom_addr_o
//   cfg_w_v_o    config write valid
//   cfg_addr_o   config write address
//   cfg_data_o   config write data
//   cfg_ready_i  downstream accepts the write when high with cfg_w_v_o
//   freeze_o     CCE freeze, high in every state except DONE
//   done_o       configuration complete

module bp_cce_cfg_loader #(
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int rom_els_p        = 256,
    localparam int lg_rom_els_lp   = (rom_els_p > 1) ? $clog2(rom_els_p) : 1,
    localparam int rom_width_lp    = cfg_addr_width_p + cfg_data_width_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        restart_i,
    output logic [lg_rom_els_lp-1:0]    rom_addr_o,
    input  logic [rom_width_lp-1:0]     rom_data_i,
    output logic                        cfg_w_v_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ready_i,
    output logic                        freeze_o,
    output logic                        done_o
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [lg_rom_els_lp-1:0] last_idx_lp = lg_rom_els_lp'(rom_els_p - 1);

    state_e                      state_r, state_n;
    logic [lg_rom_els_lp-1:0]    idx_r, idx_n;
    logic [cfg_addr_width_p-1:0] cfg_addr_r;
    logic [cfg_data_width_p-1:0] cfg_data_r;
    logic                        capture;

    logic [cfg_addr_width_p-1:0] rom_entry_addr;
    logic [cfg_data_width_p-1:0] rom_entry_data;
    logic                        rom_is_term;

    assign rom_entry_addr = rom_data_i[rom_width_lp-1 -: cfg_addr_width_p];
    assign rom_entry_data = rom_data_i[cfg_data_width_p-1:0];
    assign rom_is_term    = &rom_entry_addr;

    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        capture = 1'b0;
        unique case (state_r)
            S_RESET: begin
                idx_n   = '0;
                state_n = S_FETCH;
            end
            S_FETCH: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // rom_data_i reflects idx_r here; rom_addr_o has been stable
                // since FETCH, so the ROM output is still valid.
                if (rom_is_term) begin
                    state_n = S_DONE;
                end else begin
                    capture = 1'b1;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cfg_ready_i) begin
                    // Last-entry check comes before the increment so the
                    // index never wraps past the final ROM entry.
                    if (idx_r == last_idx_lp) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = idx_r + 1'b1;
                        state_n = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (restart_i) begin
                    idx_n   = '0;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r    <= S_RESET;
            idx_r      <= '0;
            cfg_addr_r <= '0;
            cfg_data_r <= '0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            if (capture) begin
                cfg_addr_r <= rom_entry_addr;
                cfg_data_r <= rom_entry_data;
            end
        end
    end

    // Outputs depend only on registered state, never on handshake inputs.
    assign rom_addr_o = idx_r;
    assign cfg_w_v_o  = (state_r == S_WRITE);
    assign cfg_addr_o = cfg_addr_r;
    assign cfg_data_o = cfg_data_r;
    assign freeze_o   = (state_r != S_DONE);
    assign done_o     = (state_r == S_DONE);

endmodule

// File: tb/tb_bp_cce_cfg_loader.sv
module tb_bp_cce_cfg_loader;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int ELS = 4;
    localparam int LG  = 2;
    localparam int RW  = AW + DW;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          restart_i;
    logic [LG-1:0] rom_addr_o;
    logic [RW-1:0] rom_data_i;
    logic          cfg_w_v_o;
    logic [AW-1:0] cfg_addr_o;
    logic [DW-1:0] cfg_data_o;
    logic          cfg_ready_i;
    logic          freeze_o;
    logic          done_o;

    bp_cce_cfg_loader #(
        .cfg_addr_width_p(AW),
        .cfg_data_width_p(DW),
        .rom_els_p(ELS)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n_i),
        .restart_i(restart_i),
        .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i),
        .cfg_w_v_o(cfg_w_v_o),
        .cfg_addr_o(cfg_addr_o),
        .cfg_data_o(cfg_data_o),
        .cfg_ready_i(cfg_ready_i),
        .freeze_o(freeze_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model: one-cycle read latency.
    logic [RW-1:0] rom_mem [ELS];
    always @(posedge clk) rom_data_i <= rom_mem[rom_addr_o];

    int n_checks = 0;
    int n_errors = 0;

    logic          vld_log [MAXC];
    logic          frz_log [MAXC];
    logic          done_log[MAXC];
    logic [LG-1:0] ra_log  [MAXC];
    logic [AW-1:0] ca_log  [MAXC];
    logic [DW-1:0] cd_log  [MAXC];
    int            wr_cyc  [8];
    logic [AW-1:0] wr_addr [8];
    logic [DW-1:0] wr_data [8];
    int            n_wr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: first cycle with reset_n_i=1, DUT in RESET.
    task automatic do_reset();
        reset_n_i   = 1'b0;
        restart_i   = 1'b0;
        cfg_ready_i = 1'b1;
        step();
        step();
        reset_n_i = 1'b1;
    endtask

    // Runs ncyc cycles from the current one (cycle 0), logging outputs.
    // The first 'stall' valid cycles see ready low; restart_i is pulsed in
    // cycles rs_a and rs_b.
    task automatic run_seq(input int ncyc, input int stall, input int rs_a, input int rs_b);
        int stall_left;
        stall_left = stall;
        n_wr = 0;
        for (int c = 0; c < ncyc; c++) begin
            vld_log[c]  = cfg_w_v_o;
            frz_log[c]  = freeze_o;
            done_log[c] = done_o;
            ra_log[c]   = rom_addr_o;
            ca_log[c]   = cfg_addr_o;
            cd_log[c]   = cfg_data_o;
            restart_i   = (c == rs_a) || (c == rs_b);
            if (cfg_w_v_o) begin
                if (stall_left > 0) begin
                    cfg_ready_i = 1'b0;
                    stall_left--;
                end else begin
                    cfg_ready_i = 1'b1;
                    if (n_wr < 8) begin
                        wr_cyc[n_wr]  = c;
                        wr_addr[n_wr] = cfg_addr_o;
                        wr_data[n_wr] = cfg_data_o;
                    end
                    n_wr++;
                end
            end else begin
                cfg_ready_i = 1'b1;
            end
            step();
        end
        restart_i = 1'b0;
    endtask

    function automatic int last_frozen(input int ncyc);
        int l;
        l = -1;
        for (int c = 0; c < ncyc; c++) if (frz_log[c]) l = c;
        return l;
    endfunction

    task automatic load_basic_rom();
        rom_mem[0] = {16'h0010, 32'h0000_0001};
        rom_mem[1] = {16'h0020, 32'h0000_0002};
        rom_mem[2] = {16'hFFFF, 32'h0000_0000};
        rom_mem[3] = {16'h0030, 32'h0000_0003};
    endtask

    initial begin
        reset_n_i   = 1'b0;
        restart_i   = 1'b0;
        cfg_ready_i = 1'b1;

        // Basic load
        load_basic_rom();
        do_reset();
        check_val("rst_vld",    cfg_w_v_o, 0);
        check_val("rst_addr",   cfg_addr_o, 0);
        check_val("rst_data",   cfg_data_o, 0);
        check_val("rst_romadr", rom_addr_o, 0);
        check_val("rst_freeze", freeze_o, 1);
        check_val("rst_done",   done_o, 0);
        run_seq(14, 0, -1, -1);
        check_val("basic_nwr",   n_wr, 2);
        check_val("basic_c0",    wr_cyc[0], 3);
        check_val("basic_a0",    wr_addr[0], 16'h0010);
        check_val("basic_d0",    wr_data[0], 1);
        check_val("basic_c1",    wr_cyc[1], 6);
        check_val("basic_a1",    wr_addr[1], 16'h0020);
        check_val("basic_d1",    wr_data[1], 2);
        check_val("basic_gap4",  vld_log[4], 0);
        check_val("basic_gap5",  vld_log[5], 0);
        check_val("basic_lastfrz", last_frozen(14), 8);
        check_val("basic_done8", done_log[8], 0);
        check_val("basic_done9", done_log[9], 1);

        // Backpressure: ready low for the first 5 valid cycles
        do_reset();
        run_seq(18, 5, -1, -1);
        for (int c = 3; c <= 8; c++) begin
            check_val($sformatf("bp_vld%0d", c),  vld_log[c], 1);
            check_val($sformatf("bp_addr%0d", c), ca_log[c], 16'h0010);
            check_val($sformatf("bp_data%0d", c), cd_log[c], 1);
        end
        check_val("bp_nwr",     n_wr, 2);
        check_val("bp_c0",      wr_cyc[0], 8);
        check_val("bp_c1",      wr_cyc[1], 11);
        check_val("bp_a1",      wr_addr[1], 16'h0020);
        check_val("bp_lastfrz", last_frozen(18), 13);

        // Full ROM, no terminator
        for (int i = 0; i < ELS; i++) rom_mem[i] = {16'(16'h0100 + i), 32'(32'hA0 + i)};
        do_reset();
        run_seq(20, 0, -1, -1);
        check_val("full_nwr", n_wr, 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("full_c%0d", i), wr_cyc[i], 3 + 3 * i);
            check_val($sformatf("full_a%0d", i), wr_addr[i], 16'h0100 + i);
            check_val($sformatf("full_d%0d", i), wr_data[i], 32'hA0 + i);
        end
        check_val("full_lastfrz", last_frozen(20), 12);
        check_val("full_done13",  done_log[13], 1);
        check_val("full_nowrap",  ra_log[19], 3);

        // Immediate terminator
        rom_mem[0] = {16'hFFFF, 32'h0000_0000};
        do_reset();
        run_seq(8, 0, -1, -1);
        check_val("term_nwr",     n_wr, 0);
        check_val("term_lastfrz", last_frozen(8), 2);
        check_val("term_done3",   done_log[3], 1);

        // Reset while a write is stalled
        load_basic_rom();
        do_reset();
        run_seq(6, 1000, -1, -1);
        check_val("rmw_pending", cfg_w_v_o, 1);
        reset_n_i = 1'b0;
        step();
        check_val("rmw_vld",    cfg_w_v_o, 0);
        check_val("rmw_freeze", freeze_o, 1);
        check_val("rmw_romadr", rom_addr_o, 0);
        check_val("rmw_addr",   cfg_addr_o, 0);
        reset_n_i = 1'b1;
        run_seq(14, 0, -1, -1);
        check_val("rmw_nwr", n_wr, 2);
        check_val("rmw_c0",  wr_cyc[0], 3);
        check_val("rmw_a0",  wr_addr[0], 16'h0010);
        check_val("rmw_c1",  wr_cyc[1], 6);

        // Restart: ignored in WRITE (cycle 3), honoured in DONE (cycle 10)
        do_reset();
        run_seq(22, 0, 3, 10);
        check_val("rs_nwr",    n_wr, 4);
        check_val("rs_c1",     wr_cyc[1], 6);
        check_val("rs_done10", done_log[10], 1);
        check_val("rs_frz11",  frz_log[11], 1);
        check_val("rs_done11", done_log[11], 0);
        check_val("rs_c2",     wr_cyc[2], 13);
        check_val("rs_a2",     wr_addr[2], 16'h0010);
        check_val("rs_c3",     wr_cyc[3], 16);
        check_val("rs_a3",     wr_addr[3], 16'h0020);
        check_val("rs_done19", done_log[19], 1);

        // Reset and restart together in DONE: reset wins
        reset_n_i = 1'b0;
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        check_val("rr_freeze", freeze_o, 1);
        check_val("rr_done",   done_o, 0);
        check_val("rr_addr",   cfg_addr_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
